mult_div_unit: RTL and testbench

- Multi-cycle HI/LO multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Produces the start/busy pair that the hazard unit consumes to stall F/D and flush E.
- Holds HI/LO for mfhi/mflo readout.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_arith.sv | 69 ++++++
 rtl/mult_div_unit.sv | 97 +++++++++
 tb/tb_mult_div_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the full HI/LO result.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;
    logic [31:0] safe_rt;
    logic [31:0] safe_mag_rt;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_m;
    logic [31:0] r_m;
    logic [31:0] q_s;
    logic [31:0] r_s;

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign mag_rs      = rs[31] ? (~rs + 32'd1) : rs;
    assign mag_rt      = rt[31] ? (~rt + 32'd1) : rt;
    assign safe_rt     = (rt == 32'd0) ? 32'd1 : rt;
    assign safe_mag_rt = (rt == 32'd0) ? 32'd1 : mag_rt;
    assign q_u         = rs / safe_rt;
    assign r_u         = rs % safe_rt;
    assign q_m         = mag_rs / safe_mag_rt;
    assign r_m         = mag_rs % safe_mag_rt;
    assign q_s         = (rs[31] ^ rt[31]) ? (~q_m + 32'd1) : q_m;
    assign r_s         = rs[31] ? (~r_m + 32'd1) : r_m;

    // Select the result for the requested operation.
    always_comb begin
        res_hi      = '0;
        res_lo      = '0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_hi      = r_s;
                res_lo      = q_s;
                div_by_zero = (rt == 32'd0);
            end
            MD_DIVU: begin
                res_hi      = r_u;
                res_lo      = q_u;
                div_by_zero = (rt == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_we,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [31:0] MULT_LAST = 32'(MULT_CYCLES - 1);
    localparam logic [31:0] DIV_LAST  = 32'(DIV_CYCLES - 1);

    mdu_state_e  state;
    logic [31:0] counter;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;
    logic        pending_commit;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_by_zero;
    logic        is_mul;
    logic        is_div;

    assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);

    mdu_arith u_arith (
        .op          (md_op),
        .rs          (rs_data),
        .rt          (rt_data),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    // Result is computed at issue and held; HI/LO commit together when the countdown expires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            counter        <= '0;
            busy           <= 1'b0;
            hi             <= '0;
            lo             <= '0;
            pending_hi     <= '0;
            pending_lo     <= '0;
            pending_commit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            pending_hi     <= res_hi;
                            pending_lo     <= res_lo;
                            pending_commit <= !div_by_zero;
                            counter        <= is_mul ? MULT_LAST : DIV_LAST;
                            state          <= ST_BUSY;
                            busy           <= 1'b1;
                        end
                    end else if (md_we) begin
                        if (md_op == MD_MTHI) begin
                            hi <= rs_data;
                        end else if (md_op == MD_MTLO) begin
                            lo <= rs_data;
                        end
                    end
                end
                ST_BUSY: begin
                    if (counter == 32'd0) begin
                        if (pending_commit) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int unsigned N_MUL = 5;
    localparam int unsigned N_DIV = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        md_we;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned checks;
    int unsigned failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(
        .MULT_CYCLES (N_MUL),
        .DIV_CYCLES  (N_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .md_we   (md_we),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; divide by zero leaves HI/LO alone.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] nhi, output logic [31:0] nlo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        nhi = m_hi;
        nlo = m_lo;
        case (op)
            3'd0: begin sp = sa * sb; nhi = sp[63:32]; nlo = sp[31:0]; end
            3'd1: begin up = ua * ub; nhi = up[63:32]; nlo = up[31:0]; end
            3'd2: if (b != 0) begin
                sq = sa / sb; sr = sa % sb; nhi = sr[31:0]; nlo = sq[31:0];
            end
            3'd3: if (b != 0) begin
                up = ua / ub; nlo = up[31:0]; up = ua % ub; nhi = up[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject_mtlo);
        logic [31:0] nhi, nlo;
        int unsigned n;
        model_op(op, a, b, nhi, nlo);
        n = (op <= 3'd1) ? N_MUL : N_DIV;
        @(negedge clk);
        start = 1'b1; md_op = op; rs_data = a; rt_data = b;
        for (int unsigned j = 0; j < n; j++) begin
            @(negedge clk);
            start = 1'b0;
            md_we = 1'b0;
            if (inject_mtlo && j == 1) begin
                md_we = 1'b1; md_op = 3'd5; rs_data = 32'h0000AAAA;
            end
            check_eq("busy_during", {31'd0, busy}, 32'd1);
            check_eq("hi_hold", hi, m_hi);
            check_eq("lo_hold", lo, m_lo);
        end
        @(negedge clk);
        md_we = 1'b0;
        m_hi = nhi;
        m_lo = nlo;
        check_eq("busy_done", {31'd0, busy}, 32'd0);
        check_eq("hi_result", hi, m_hi);
        check_eq("lo_result", lo, m_lo);
    endtask

    task automatic write_hilo(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        md_we = 1'b1; md_op = op; rs_data = v;
        @(negedge clk);
        md_we = 1'b0;
        if (op == 3'd4) m_hi = v; else m_lo = v;
        check_eq("mt_busy", {31'd0, busy}, 32'd0);
        check_eq("mt_hi", hi, m_hi);
        check_eq("mt_lo", lo, m_lo);
    endtask

    task automatic noop_start(input logic [2:0] op);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_data = $urandom; rt_data = $urandom;
        @(negedge clk);
        start = 1'b0;
        check_eq("noop_busy", {31'd0, busy}, 32'd0);
        check_eq("noop_hi", hi, m_hi);
        check_eq("noop_lo", lo, m_lo);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] rop;
        checks = 0; failures = 0;
        m_hi = '0; m_lo = '0;
        reset = 1'b0; start = 1'b0; md_op = '0; md_we = 1'b0;
        rs_data = '0; rt_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        check_eq("mult_hi_const", hi, 32'hFFFFFFFF);
        check_eq("mult_lo_const", lo, 32'hFFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check_eq("multu_hi_const", hi, 32'hFFFFFFFE);
        check_eq("multu_lo_const", lo, 32'h00000001);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check_eq("div_hi_const", hi, 32'hFFFFFFFF);
        check_eq("div_lo_const", lo, 32'hFFFFFFFD);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check_eq("divovf_hi_const", hi, 32'h00000000);
        check_eq("divovf_lo_const", lo, 32'h80000000);

        write_hilo(3'd4, 32'h00001234);
        write_hilo(3'd5, 32'h00005678);
        run_op(3'd3, 32'd9, 32'd0, 1'b0);
        check_eq("dbz_hi_const", hi, 32'h00001234);
        check_eq("dbz_lo_const", lo, 32'h00005678);

        run_op(3'd0, 32'd7, 32'd6, 1'b1);
        check_eq("mtlo_ignored_lo", lo, 32'd42);

        noop_start(3'd6);
        noop_start(3'd7);
        noop_start(3'd4);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 5));
            if (rop >= 3'd4) write_hilo(rop, rnd_word());
            else run_op(rop, rnd_word(), rnd_word(), 1'b0);
        end

        // Reset during busy cycle 3 of a divide: abort with no later commit.
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; rs_data = 32'd100; rt_data = 32'd7;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            start = 1'b0;
            check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_hi", hi, 32'd0);
        check_eq("abort_lo", lo, 32'd0);
        repeat (N_DIV + 2) @(negedge clk);
        check_eq("abort_no_commit_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_no_commit_hi", hi, 32'd0);
        check_eq("abort_no_commit_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
